// File: rtl/wash_pkg.sv
// Shared definitions for the wash panel: state encoding, program codes and
// program durations in seconds.
package wash_pkg;

  localparam int REMAIN_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_RUNNING  = 3'd2,
    ST_PAUSED   = 3'd3,
    ST_COMPLETE = 3'd4,
    ST_FAULT    = 3'd5
  } panel_state_t;

  typedef enum logic [1:0] {
    PROG_NORMAL = 2'b00,
    PROG_DOUBLE = 2'b01,
    PROG_DRY    = 2'b10,
    PROG_ALIAS  = 2'b11
  } prog_t;

  // Phase durations in seconds
  localparam int FILL_SEC  = 60;
  localparam int WASH_SEC  = 300;
  localparam int RINSE_SEC = 300;
  localparam int SPIN_SEC  = 120;
  localparam int DRY_SEC   = 600;
  localparam int STEAM_SEC = 600;

  // Program totals: a double wash repeats the wash and rinse phases
  localparam int NORMAL_TOTAL = FILL_SEC + WASH_SEC + RINSE_SEC + SPIN_SEC + DRY_SEC;
  localparam int DOUBLE_TOTAL = NORMAL_TOTAL + WASH_SEC + RINSE_SEC;
  localparam int DRY_TOTAL    = STEAM_SEC;

  // Code 11 is not a real program and behaves as normal
  function automatic logic [1:0] prog_normalize(input logic [1:0] p);
    return (p == PROG_ALIAS) ? PROG_NORMAL : p;
  endfunction

  function automatic logic [REMAIN_W-1:0] prog_duration(input logic [1:0] p);
    logic [REMAIN_W-1:0] d;
    case (p)
      PROG_DOUBLE: d = REMAIN_W'(DOUBLE_TOTAL);
      PROG_DRY:    d = REMAIN_W'(DRY_TOTAL);
      default:     d = REMAIN_W'(NORMAL_TOTAL);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wash_sec_tick.sv
// Seconds prescaler: counts enabled clocks and emits a one-cycle tick on the
// last clock of each second. Holds its count while disabled.
module wash_sec_tick #(
  parameter int CLKS_PER_SEC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;

  logic [CNT_W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == CNT_W'(CLKS_PER_SEC - 1));

  // Count enabled cycles, wrapping at the end of each second
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/wash_panel_ctrl.sv
// Front-panel command sequencer for the washing machine: latches the program,
// issues the start pulse, handles pause/resume, counts down the remaining
// seconds and holds the door lock. Every output is registered.
// Optional watchdog: define WASH_PANEL_TIMEOUT_EN to flag a fault when the
// machine never reports done within TIMEOUT_SEC seconds after the countdown ends.
module wash_panel_ctrl
  import wash_pkg::*;
#(
  parameter int CLKS_PER_SEC = 1,
  parameter int START_PULSE  = 2
`ifdef WASH_PANEL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_SEC  = 30
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_btn,
  input  logic                pause_btn,
  input  logic [1:0]          prog_sel,
  input  logic                done_in,
  output logic                start_out,
  output logic                double_wash_out,
  output logic                dry_wash_out,
  output logic                time_pause_out,
  output logic                door_lock,
  output logic [REMAIN_W-1:0] remaining_sec,
  output logic [2:0]          state_out,
  output logic                fault
);

  panel_state_t        state_reg, state_next;
  logic [1:0]          prog_reg, prog_next;
  logic [REMAIN_W-1:0] remaining_reg, remaining_next;
  logic [3:0]          pulse_reg, pulse_next;
  logic                done_prev_reg;
  logic                done_rise;
  logic                presc_en, presc_clr, sec_tick;
  logic                active_next;
  logic                start_out_reg, double_wash_reg, dry_wash_reg;
  logic                time_pause_reg, door_lock_reg;

`ifdef WASH_PANEL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_SEC + 1);
  logic [WD_W-1:0] wd_reg, wd_next;
  logic            fault_reg;
`endif

  // Only a fresh low-to-high transition of done counts, so a done left high
  // from a previous run cannot end a new one
  assign done_rise = done_in && !done_prev_reg;

  // The second counter only advances on cycles that stay in RUNNING
  assign presc_en = (state_reg == ST_RUNNING) && !done_rise && !pause_btn;

  wash_sec_tick #(
    .CLKS_PER_SEC(CLKS_PER_SEC)
  ) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (sec_tick)
  );

  // Next-state, countdown and watchdog decisions
  always_comb begin
    state_next     = state_reg;
    prog_next      = prog_reg;
    remaining_next = remaining_reg;
    pulse_next     = pulse_reg;
    presc_clr      = 1'b0;
`ifdef WASH_PANEL_TIMEOUT_EN
    wd_next        = wd_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_COMPLETE: begin
        if (start_btn) begin
          prog_next      = prog_normalize(prog_sel);
          remaining_next = prog_duration(prog_sel);
          pulse_next     = '0;
          presc_clr      = 1'b1;
          state_next     = ST_ARMED;
`ifdef WASH_PANEL_TIMEOUT_EN
          wd_next        = '0;
`endif
        end
      end
      ST_ARMED: begin
        if (pulse_reg == 4'(START_PULSE - 1)) begin
          state_next = ST_RUNNING;
        end else begin
          pulse_next = pulse_reg + 4'd1;
        end
      end
      ST_RUNNING: begin
        if (done_rise) begin
          state_next     = ST_COMPLETE;
          remaining_next = '0;
        end else if (pause_btn) begin
          state_next = ST_PAUSED;
        end else if (sec_tick) begin
          if (remaining_reg != '0) begin
            remaining_next = remaining_reg - 1'b1;
          end else begin
`ifdef WASH_PANEL_TIMEOUT_EN
            wd_next = wd_reg + 1'b1;
            if (wd_next == WD_W'(TIMEOUT_SEC)) begin
              state_next = ST_FAULT;
            end
`endif
          end
        end
      end
      ST_PAUSED: begin
        if (done_rise) begin
          state_next     = ST_COMPLETE;
          remaining_next = '0;
        end else if (pause_btn) begin
          state_next = ST_RUNNING;
        end
      end
      default: begin
        state_next = state_reg;
      end
    endcase
    active_next = (state_next == ST_ARMED) || (state_next == ST_RUNNING) ||
                  (state_next == ST_PAUSED);
  end

  // State, program, countdown and edge-detector registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      prog_reg      <= '0;
      remaining_reg <= '0;
      pulse_reg     <= '0;
      done_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prog_reg      <= prog_next;
      remaining_reg <= remaining_next;
      pulse_reg     <= pulse_next;
      done_prev_reg <= done_in;
    end
  end

  // Machine command outputs registered from the next-state decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_out_reg   <= 1'b0;
      double_wash_reg <= 1'b0;
      dry_wash_reg    <= 1'b0;
      time_pause_reg  <= 1'b0;
      door_lock_reg   <= 1'b0;
    end else begin
      start_out_reg   <= (state_next == ST_ARMED);
      double_wash_reg <= active_next && (prog_next == PROG_DOUBLE);
      dry_wash_reg    <= active_next && (prog_next == PROG_DRY);
      time_pause_reg  <= (state_next == ST_PAUSED);
      door_lock_reg   <= active_next;
    end
  end

`ifdef WASH_PANEL_TIMEOUT_EN
  // Watchdog counter and sticky fault flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_reg    <= '0;
      fault_reg <= 1'b0;
    end else begin
      wd_reg    <= wd_next;
      fault_reg <= (state_next == ST_FAULT);
    end
  end
  assign fault = fault_reg;
`else
  assign fault = 1'b0;
`endif

  assign start_out       = start_out_reg;
  assign double_wash_out = double_wash_reg;
  assign dry_wash_out    = dry_wash_reg;
  assign time_pause_out  = time_pause_reg;
  assign door_lock       = door_lock_reg;
  assign remaining_sec   = remaining_reg;
  assign state_out       = state_reg;

endmodule
